core_run_sequencer: RTL and testbench

- Synthesizable, parametrised successor to the testbench single-thread core-release logic.
- Holds N RISC-V tiles in reset until the program is loaded, then releases their core resets one at a time (sequential) or all together (parallel).
- Records per-core pass/fail/timeout and exposes a done/busy handshake to the DVT flag bridge.
- Sits between the cosim top (program_loaded, pass/fail from core drivers) and the tile/core reset nets.

---
 rtl/core_run_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_core_run_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_sequencer.sv
// Core run sequencer: holds tiles in reset until the program image is loaded,
// then releases core resets one at a time or all together and records the
// per-core pass/fail/timeout outcome behind a busy/done handshake.
module core_run_sequencer #(
   parameter int NUM_CORES    = 4,
   parameter int TIMEOUT_W    = 32,
   parameter int RESET_CYCLES = 2,
   localparam int AW          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 mode,
   input  logic                 reset_between,
   input  logic [NUM_CORES-1:0] core_mask,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   input  logic                 program_loaded,
   input  logic [NUM_CORES-1:0] core_pass,
   input  logic [NUM_CORES-1:0] core_fail,
   output logic [NUM_CORES-1:0] tile_reset,
   output logic [NUM_CORES-1:0] core_reset,
   output logic                 busy,
   output logic                 done,
   output logic [AW-1:0]        active_core,
   output logic [NUM_CORES-1:0] pass_vec,
   output logic [NUM_CORES-1:0] fail_vec,
   output logic [NUM_CORES-1:0] timeout_vec
);

   localparam int CW = $clog2(NUM_CORES + 1);
   localparam int RW = $clog2(RESET_CYCLES + 1) + 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LOAD,
      TILE_RST,
      SELECT,
      RUN,
      DONE
   } state_t;

   state_t               state;
   logic                 modeQ;
   logic                 rbQ;
   logic [NUM_CORES-1:0] maskQ;
   logic [TIMEOUT_W-1:0] limitQ;
   logic [TIMEOUT_W-1:0] timerQ;
   logic [CW-1:0]        cursorQ;
   logic [AW-1:0]        curCore;
   logic [RW-1:0]        rstCnt;
   logic [NUM_CORES-1:0] finishedQ;

   logic                 seqFound;
   logic [AW-1:0]        seqIdx;
   logic                 curPass;
   logic                 curFail;
   logic                 timeoutHit;
   logic [NUM_CORES-1:0] pending;
   logic [NUM_CORES-1:0] parStat;
   logic [NUM_CORES-1:0] parPass;
   logic [NUM_CORES-1:0] parFail;
   logic [NUM_CORES-1:0] parTo;
   logic [NUM_CORES-1:0] finNext;

   // Next-core search, timeout detect and per-core parallel completion terms
   always_comb begin
      seqFound = 1'b0;
      seqIdx   = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (!seqFound && maskQ[i] && (i >= 32'(cursorQ))) begin
            seqFound = 1'b1;
            seqIdx   = AW'(i);
         end
      end
      curPass    = core_pass[curCore];
      curFail    = core_fail[curCore];
      timeoutHit = (limitQ != '0) && (timerQ == limitQ - TIMEOUT_W'(1));
      pending    = maskQ & ~finishedQ;
      parStat    = pending & (core_pass | core_fail);
      parPass    = parStat & core_pass & ~core_fail;
      parFail    = parStat & core_fail;
      parTo      = timeoutHit ? (pending & ~parStat) : '0;
      finNext    = finishedQ | parStat | parTo;
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         modeQ       <= 1'b0;
         rbQ         <= 1'b0;
         maskQ       <= '0;
         limitQ      <= '0;
         timerQ      <= '0;
         cursorQ     <= '0;
         curCore     <= '0;
         rstCnt      <= '0;
         finishedQ   <= '0;
         tile_reset  <= '0;
         core_reset  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         active_core <= '0;
         pass_vec    <= '0;
         fail_vec    <= '0;
         timeout_vec <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (state == DONE) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
               if (start) begin
                  modeQ       <= mode;
                  rbQ         <= reset_between;
                  maskQ       <= core_mask;
                  limitQ      <= timeout_limit;
                  pass_vec    <= '0;
                  fail_vec    <= '0;
                  timeout_vec <= '0;
                  finishedQ   <= '0;
                  active_core <= '0;
                  done        <= 1'b0;
                  busy        <= 1'b1;
                  if (core_mask == '0) begin
                     tile_reset <= '0;
                     core_reset <= '0;
                     state      <= DONE;
                  end else begin
                     tile_reset <= '1;
                     core_reset <= '1;
                     state      <= WAIT_LOAD;
                  end
               end
            end
            WAIT_LOAD: begin
               if (program_loaded) begin
                  tile_reset <= '0;
                  cursorQ    <= '0;
                  state      <= SELECT;
               end
            end
            SELECT: begin
               if (modeQ) begin
                  core_reset <= core_reset & ~maskQ;
                  timerQ     <= '0;
                  finishedQ  <= '0;
                  state      <= RUN;
               end else if (!seqFound) begin
                  state <= DONE;
               end else begin
                  curCore <= seqIdx;
                  if (rbQ) begin
                     tile_reset <= '1;
                     rstCnt     <= RW'(1);
                     state      <= TILE_RST;
                  end else begin
                     core_reset[seqIdx] <= 1'b0;
                     active_core        <= seqIdx;
                     timerQ             <= '0;
                     state              <= RUN;
                  end
               end
            end
            TILE_RST: begin
               // The tile reset window ends on the same edge the core is released
               if (rstCnt == RW'(RESET_CYCLES)) begin
                  tile_reset          <= '0;
                  core_reset[curCore] <= 1'b0;
                  active_core         <= curCore;
                  timerQ              <= '0;
                  state               <= RUN;
               end else begin
                  rstCnt <= rstCnt + RW'(1);
               end
            end
            RUN: begin
               if (timerQ != '1) timerQ <= timerQ + TIMEOUT_W'(1);
               if (modeQ) begin
                  pass_vec    <= pass_vec | parPass;
                  fail_vec    <= fail_vec | parFail;
                  timeout_vec <= timeout_vec | parTo;
                  core_reset  <= core_reset | parStat | parTo;
                  finishedQ   <= finNext;
                  if ((finNext & maskQ) == maskQ) state <= DONE;
               end else if (curPass || curFail || timeoutHit) begin
                  if (curFail)      fail_vec[curCore]    <= 1'b1;
                  else if (curPass) pass_vec[curCore]    <= 1'b1;
                  else              timeout_vec[curCore] <= 1'b1;
                  core_reset[curCore] <= 1'b1;
                  cursorQ             <= CW'(curCore) + CW'(1);
                  active_core         <= '0;
                  state               <= SELECT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_run_sequencer.sv
// Self-checking bench for core_run_sequencer: expected transaction results are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_core_run_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mode;
   logic        reset_between;
   logic [3:0]  core_mask;
   logic [31:0] timeout_limit;
   logic        program_loaded;
   logic [3:0]  core_pass;
   logic [3:0]  core_fail;
   logic [3:0]  tile_reset;
   logic [3:0]  core_reset;
   logic        busy;
   logic        done;
   logic [1:0]  active_core;
   logic [3:0]  pass_vec;
   logic [3:0]  fail_vec;
   logic [3:0]  timeout_vec;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sbQ[$];
   int   checks   = 0;
   int   failures = 0;
   int   tileRun;

   core_run_sequencer #(
      .NUM_CORES(4),
      .TIMEOUT_W(32),
      .RESET_CYCLES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .mode(mode),
      .reset_between(reset_between),
      .core_mask(core_mask),
      .timeout_limit(timeout_limit),
      .program_loaded(program_loaded),
      .core_pass(core_pass),
      .core_fail(core_fail),
      .tile_reset(tile_reset),
      .core_reset(core_reset),
      .busy(busy),
      .done(done),
      .active_core(active_core),
      .pass_vec(pass_vec),
      .fail_vec(fail_vec),
      .timeout_vec(timeout_vec)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pushExp(input string tag, input logic [31:0] val);
      sbQ.push_back('{tag, val});
   endtask

   task automatic popCheck(input logic [31:0] got);
      exp_t e;
      if (sbQ.size() == 0) begin
         checkVal("sbEmpty", 32'd1, 32'd0);
      end else begin
         e = sbQ.pop_front();
         checkVal(e.tag, got, e.val);
      end
   endtask

   task automatic pulseStart(input logic [3:0] m, input logic md, input logic rb, input logic [31:0] lim);
      core_mask     = m;
      mode          = md;
      reset_between = rb;
      timeout_limit = lim;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for any core_reset bit to drop; reports how many cycles tile_reset
   // was fully asserted immediately before that release.
   task automatic waitRelease(output int run);
      int n;
      run = 0;
      n   = 0;
      while (core_reset == 4'b1111 && n < 200) begin
         if (tile_reset == 4'b1111) run++;
         else run = 0;
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkVal("relWait", 32'd0, 32'd1);
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) checkVal("doneWait", 32'd0, 32'd1);
   endtask

   task automatic popResults();
      popCheck(32'(pass_vec));
      popCheck(32'(fail_vec));
      popCheck(32'(timeout_vec));
      popCheck(32'(busy));
      popCheck(32'(tile_reset));
      popCheck(32'(core_reset));
   endtask

   task automatic pushResults(input string t, input logic [3:0] p, input logic [3:0] f, input logic [3:0] o);
      pushExp({t, "Pass"}, 32'(p));
      pushExp({t, "Fail"}, 32'(f));
      pushExp({t, "Tout"}, 32'(o));
      pushExp({t, "Busy"}, 32'd0);
      pushExp({t, "Tile"}, 32'd0);
      pushExp({t, "Core"}, 32'hF);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; reset_between = 1'b0;
      core_mask = '0; timeout_limit = '0; program_loaded = 1'b0;
      core_pass = '0; core_fail = '0;
      repeat (3) @(negedge clk);
      checkVal("rstTile", 32'(tile_reset), 32'd0);
      checkVal("rstCore", 32'(core_reset), 32'd0);
      checkVal("rstBusy", 32'(busy), 32'd0);
      checkVal("rstDone", 32'(done), 32'd0);
      checkVal("rstVecs", 32'({pass_vec, fail_vec, timeout_vec}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Sequential, mask 0101, program arrives late
      pulseStart(4'b0101, 1'b0, 1'b0, 32'd0);
      checkVal("t1Busy", 32'(busy), 32'd1);
      checkVal("t1Tile", 32'(tile_reset), 32'hF);
      checkVal("t1Core", 32'(core_reset), 32'hF);
      repeat (5) @(negedge clk);
      checkVal("t1Hold", 32'(tile_reset), 32'hF);
      program_loaded = 1'b1;
      pushExp("t1Rel0", 32'b1110);
      pushExp("t1Act0", 32'd0);
      waitRelease(tileRun);
      popCheck(32'(core_reset));
      popCheck(32'(active_core));
      core_pass = 4'b0001;
      @(negedge clk);
      core_pass = '0;
      pushExp("t1Rel2", 32'b1011);
      pushExp("t1Act2", 32'd2);
      waitRelease(tileRun);
      popCheck(32'(core_reset));
      popCheck(32'(active_core));
      core_fail = 4'b0100;
      @(negedge clk);
      core_fail = '0;
      pushResults("t1", 4'b0001, 4'b0100, 4'b0000);
      waitDone();
      popResults();

      // Parallel, all cores, limit 100, cores 2/3 time out
      pulseStart(4'b1111, 1'b1, 1'b0, 32'd100);
      checkVal("t2Done", 32'(done), 32'd0);
      pushExp("t2Rel", 32'b0000);
      waitRelease(tileRun);
      popCheck(32'(core_reset));
      core_pass = 4'b0011;
      @(negedge clk);
      core_pass = '0;
      pushExp("t2Part", 32'b0011);
      popCheck(32'(core_reset));
      repeat (98) @(negedge clk);
      pushExp("t2ToBefore", 32'd0);
      popCheck(32'(timeout_vec));
      @(negedge clk);
      pushExp("t2ToAt", 32'b1100);
      popCheck(32'(timeout_vec));
      pushResults("t2", 4'b0011, 4'b0000, 4'b1100);
      waitDone();
      popResults();

      // Sequential with reset-between; core 1 sees pass and fail together
      pulseStart(4'b0011, 1'b0, 1'b1, 32'd0);
      pushExp("t3Run0", 32'd2);
      pushExp("t3Rel0", 32'b1110);
      pushExp("t3Act0", 32'd0);
      pushExp("t3Tile0", 32'd0);
      waitRelease(tileRun);
      popCheck(32'(tileRun));
      popCheck(32'(core_reset));
      popCheck(32'(active_core));
      popCheck(32'(tile_reset));
      core_pass = 4'b0001;
      @(negedge clk);
      core_pass = '0;
      pushExp("t3Run1", 32'd2);
      pushExp("t3Rel1", 32'b1101);
      pushExp("t3Act1", 32'd1);
      waitRelease(tileRun);
      popCheck(32'(tileRun));
      popCheck(32'(core_reset));
      popCheck(32'(active_core));
      core_pass = 4'b0010;
      core_fail = 4'b0010;
      @(negedge clk);
      core_pass = '0;
      core_fail = '0;
      pushResults("t4", 4'b0001, 4'b0010, 4'b0000);
      waitDone();
      popResults();

      // Stuck pass at release, unmasked fail ignored, last-index timeout
      core_fail = 4'b0010;
      pulseStart(4'b1001, 1'b0, 1'b0, 32'd5);
      core_pass = 4'b0001;
      pushExp("t6Rel0", 32'b1110);
      waitRelease(tileRun);
      popCheck(32'(core_reset));
      @(negedge clk);
      core_pass = '0;
      pushExp("t6Stuck", 32'b0001);
      popCheck(32'(pass_vec));
      pushExp("t6Rel3", 32'b0111);
      pushExp("t6Act3", 32'd3);
      waitRelease(tileRun);
      popCheck(32'(core_reset));
      popCheck(32'(active_core));
      repeat (4) @(negedge clk);
      pushExp("t6ToBefore", 32'd0);
      popCheck(32'(timeout_vec));
      @(negedge clk);
      pushExp("t6ToAt", 32'b1000);
      popCheck(32'(timeout_vec));
      pushResults("t6", 4'b0001, 4'b0000, 4'b1000);
      waitDone();
      popResults();
      core_fail = '0;

      // Reset mid-run, start while busy, empty-mask start
      pulseStart(4'b0011, 1'b0, 1'b0, 32'd0);
      waitRelease(tileRun);
      core_pass = 4'b0001;
      @(negedge clk);
      core_pass = '0;
      waitRelease(tileRun);
      pulseStart(4'b1111, 1'b1, 1'b0, 32'd0);
      checkVal("t5IgnCore", 32'(core_reset), 32'b1101);
      checkVal("t5IgnAct", 32'(active_core), 32'd1);
      checkVal("t5IgnBusy", 32'(busy), 32'd1);
      checkVal("t5IgnPass", 32'(pass_vec), 32'b0001);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkVal("t5RstTile", 32'(tile_reset), 32'd0);
      checkVal("t5RstCore", 32'(core_reset), 32'd0);
      checkVal("t5RstBusy", 32'(busy), 32'd0);
      checkVal("t5RstVecs", 32'({pass_vec, fail_vec, timeout_vec}), 32'd0);
      checkVal("t5RstAct", 32'(active_core), 32'd0);
      pulseStart(4'b0000, 1'b0, 1'b0, 32'd0);
      checkVal("t5ZeroDone0", 32'(done), 32'd0);
      checkVal("t5ZeroRst0", 32'({tile_reset, core_reset}), 32'd0);
      @(negedge clk);
      checkVal("t5ZeroDone1", 32'(done), 32'd1);
      checkVal("t5ZeroBusy1", 32'(busy), 32'd0);
      checkVal("t5ZeroRst1", 32'({tile_reset, core_reset}), 32'd0);

      checkVal("sbLeft", 32'(sbQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
